inst_sram_axi_bridge: RTL

Read-only bridge between the IF stage's SRAM-like instruction port and an AXI4 read channel (AR/R). Sits directly upstream of IF: it accepts IF fetch requests with `addr_ok`, issues single-beat AXI reads, and returns instruction words to IF with `data_ok` in request order. IF never issues stores and never drops a `data_ok`, even for cancelled fetches. The bridge therefore tracks every accepted request until its data returns.

---
 rtl/inst_sram_axi_bridge.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/inst_sram_axi_bridge.sv
// inst_sram_axi_bridge
// Read-only bridge from the IF stage SRAM-like instruction port to an AXI4
// read channel (AR/R). Accepts fetches with addr_ok, issues one single-beat
// AXI read per fetch, and returns instruction words with data_ok in request
// order. Every accepted fetch is tracked until its data returns, because IF
// consumes a data_ok even for fetches it has cancelled.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   inst_sram_*            IF-side request/response (wr/wstrb/wdata ignored)
//   ar*                    AXI read address channel (single beat, INCR)
//   r*                     AXI read data channel (rid/rresp/rlast ignored)
//
// Parameters
//   ARID                   constant AXI id driven on arid
//   MAX_OUTSTANDING        fetches accepted but not yet answered (1..4)
//
// Build option
//   INST_BRIDGE_RBUF_EN    register R data in a one-entry buffer before IF;
//                          undefined gives a combinational R pass-through.

module inst_sram_axi_bridge #(
  parameter logic [3:0]  ARID            = 4'd0,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // IF instruction port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  ar_state_e        state_q, state_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [2:0]       arsize_q, arsize_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Inputs that a read-only single-beat bridge has no use for.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                           rid, rresp, rlast};

  // Constant AR attributes: single-beat INCR, no lock/cache/prot.
  assign arid    = ARID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = (state_q == AR_BUSY);

  // Same-cycle accept from registered state only; held low while in reset.
  assign inst_sram_addr_ok = resetn && (state_q == AR_IDLE) && inst_sram_req
                             && (cnt_q < CNT_MAX);
  assign accept            = inst_sram_req && inst_sram_addr_ok;

`ifdef INST_BRIDGE_RBUF_EN
  logic        rbuf_valid_q, rbuf_valid_d;
  logic [31:0] rbuf_data_q, rbuf_data_d;

  // Buffer takes a beat only when empty; it drains in its data_ok cycle.
  assign rready            = (cnt_q != '0) && !rbuf_valid_q;
  assign inst_sram_data_ok = rbuf_valid_q;
  assign inst_sram_rdata   = rbuf_data_q;

  // R buffer next state.
  always_comb begin
    rbuf_valid_d = rbuf_valid_q;
    rbuf_data_d  = rbuf_data_q;
    if (rvalid && rready) begin
      rbuf_valid_d = 1'b1;
      rbuf_data_d  = rdata;
    end else if (rbuf_valid_q) begin
      rbuf_valid_d = 1'b0;
    end
  end

  // R buffer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rbuf_valid_q <= 1'b0;
      rbuf_data_q  <= 32'd0;
    end else begin
      rbuf_valid_q <= rbuf_valid_d;
      rbuf_data_q  <= rbuf_data_d;
    end
  end
`else
  // Pass-through R path: a beat is taken whenever a fetch is outstanding.
  assign rready            = (cnt_q != '0);
  assign inst_sram_data_ok = rvalid && rready;
  assign inst_sram_rdata   = rdata;
`endif

  // AR FSM and outstanding counter next state.
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;
    cnt_d    = cnt_q;

    case (state_q)
      AR_IDLE: begin
        if (accept) begin
          araddr_d = inst_sram_addr;
          arsize_d = {1'b0, inst_sram_size};
          state_d  = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (arready) begin
          state_d = AR_IDLE;
        end
      end
      default: state_d = AR_IDLE;
    endcase

    // Accept and data_ok in the same cycle leave the count unchanged.
    case ({accept, inst_sram_data_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // AR FSM and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= AR_IDLE;
      araddr_q <= 32'd0;
      arsize_q <= 3'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arsize_q <= arsize_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
